// File: rtl/iter_shift_rotate_unit.sv
// iter_shift_rotate_unit
// Multi-cycle shift/rotate unit. Operand A is moved by b mod WIDTH positions,
// at most STEP positions per RUN cycle, behind a start/busy/done handshake.
// The result register feeds the Z/RZ writeback path and is held until the
// next operation completes.
module iter_shift_rotate_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int AW = $clog2(WIDTH);

  // STEP_W can hold STEP == WIDTH for the "last move" compare; STEP_K is only
  // used when rem > STEP, which implies STEP < WIDTH, so truncation is harmless.
  localparam logic [AW:0]   STEP_W = (AW+1)'(STEP);
  localparam logic [AW-1:0] STEP_K = AW'(STEP);

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [WIDTH-1:0]  work_r;
  logic [2:0]        op_r;
  logic [AW-1:0]     rem_r;
  logic              load_s;
  logic              last_s;
  logic [AW-1:0]     move_k_s;
  logic [WIDTH-1:0]  moved_s;
  logic              busy_next_s;
  logic              done_next_s;
  logic              unused_b_s;

  // One move of k positions (k < WIDTH). Rotates use a doubled word so bits
  // leaving one end re-enter at the other; SHRA keeps the sign bit in place,
  // so the original sign is preserved across successive steps.
  function automatic logic [WIDTH-1:0] move_bits(
    input logic [WIDTH-1:0] w,
    input logic [2:0]       o,
    input logic [AW-1:0]    k
  );
    logic [2*WIDTH-1:0] dbl;
    dbl       = {w, w};
    move_bits = w;
    case (o)
      OP_SHR:  move_bits = w >> k;
      OP_SHRA: move_bits = $signed(w) >>> k;
      OP_SHL:  move_bits = w << k;
      OP_ROR: begin
        dbl       = dbl >> k;
        move_bits = dbl[WIDTH-1:0];
      end
      OP_ROL: begin
        dbl       = dbl << k;
        move_bits = dbl[2*WIDTH-1:WIDTH];
      end
      default: move_bits = w;
    endcase
  endfunction

  // Only the low AW bits of the amount matter; the rest is deliberately dropped.
  assign unused_b_s = ^b[WIDTH-1:AW];

  assign load_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign last_s   = ({1'b0, rem_r} <= STEP_W);
  assign move_k_s = last_s ? rem_r : STEP_K;
  assign moved_s  = move_bits(work_r, op_r, move_k_s);

  // State register; clear forces IDLE from any state.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; start during RUN is ignored, not queued.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_next_s = ST_DONE;
        else        state_next_s = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered.
  always_comb begin
    busy_next_s = 1'b0;
    done_next_s = 1'b0;
    case (state_next_s)
      ST_RUN:  busy_next_s = 1'b1;
      ST_DONE: done_next_s = 1'b1;
      default: begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs; result only updates on the final move.
  always_ff @(posedge clock) begin
    if (clear) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      work_r <= '0;
      op_r   <= 3'd0;
      rem_r  <= '0;
    end else begin
      busy <= busy_next_s;
      done <= done_next_s;
      if (load_s) begin
        work_r <= a;
        op_r   <= op;
        // Reserved ops behave as a zero-length move, returning a unchanged.
        rem_r  <= (op > OP_ROL) ? '0 : b[AW-1:0];
      end else if (state_r == ST_RUN) begin
        work_r <= moved_s;
        if (last_s) begin
          result <= moved_s;
          rem_r  <= '0;
        end else begin
          rem_r  <= rem_r - STEP_K;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_shift_rotate_unit.sv
// Bench for iter_shift_rotate_unit: three instances (STEP 1, 4, 32) share
// operand inputs and clear, each with its own start and scoreboard queue.
module tb_iter_shift_rotate_unit;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        start1, start4, start32;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy1, busy4, busy32;
  logic        done1, done4, done32;
  logic [31:0] result1, result4, result32;

  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t q32[$];

  always #5 clock = ~clock;

  // Cycle counter used for latency expectations.
  always @(posedge clock) cyc <= cyc + 1;

  iter_shift_rotate_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clock(clock), .clear(clear), .start(start1), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy1), .done(done1), .result(result1));
  iter_shift_rotate_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clock(clock), .clear(clear), .start(start4), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy4), .done(done4), .result(result4));
  iter_shift_rotate_unit #(.WIDTH(32), .STEP(32)) u_dut32 (
    .clock(clock), .clear(clear), .start(start32), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy32), .done(done32), .result(result32));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: bit-serial moves, independent of the RTL's shifter structure.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    int amt;
    logic [31:0] r;
    amt = int'(y[4:0]);
    r = x;
    for (int i = 0; i < amt; i++) begin
      case (o)
        3'd0: r = {1'b0, r[31:1]};
        3'd1: r = {r[31], r[31:1]};
        3'd2: r = {r[30:0], 1'b0};
        3'd3: r = {r[0], r[31:1]};
        3'd4: r = {r[30:0], r[31]};
        default: r = x;
      endcase
    end
    return r;
  endfunction

  function automatic int lat(input logic [2:0] o, input logic [31:0] y, input int step);
    int amt;
    amt = int'(y[4:0]);
    if (o > 3'd4 || amt == 0) return 1;
    return (amt + step - 1) / step;
  endfunction

  // Drive one start pulse to the selected instances and record expectations.
  task automatic drive_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] expv, input logic [2:0] mask);
    exp_t e;
    op_i = o; a_i = x; b_i = y;
    start1 = mask[0]; start4 = mask[1]; start32 = mask[2];
    e.res = expv;
    if (mask[0]) begin e.cyc = cyc + 1 + lat(o, y, 1);  q1.push_back(e);  end
    if (mask[1]) begin e.cyc = cyc + 1 + lat(o, y, 4);  q4.push_back(e);  end
    if (mask[2]) begin e.cyc = cyc + 1 + lat(o, y, 32); q32.push_back(e); end
    @(posedge clock);
    #1;
    start1 = 1'b0; start4 = 1'b0; start32 = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 3'($urandom);
  endtask

  // Bounded drain of all scoreboards.
  task automatic wait_all();
    for (int i = 0; i < 300; i++) begin
      if (q1.size() == 0 && q4.size() == 0 && q32.size() == 0) break;
      @(negedge clock);
      #1;
    end
    check_eq("drain", 32'(q1.size() + q4.size() + q32.size()), 32'd0);
    q1.delete(); q4.delete(); q32.delete();
  endtask

  // Scoreboard monitors: compare result and done cycle when done pulses.
  always @(negedge clock) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) check_eq("s1_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check_eq("s1_result", result1, e.res);
        check_eq("s1_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) check_eq("s4_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        check_eq("s4_result", result4, e.res);
        check_eq("s4_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (done32) begin
      if (q32.size() == 0) check_eq("s32_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q32.pop_front();
        check_eq("s32_result", result32, e.res);
        check_eq("s32_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    clear = 1'b1;
    start1 = 1'b0; start4 = 1'b0; start32 = 1'b0;
    op_i = 3'd0; a_i = 32'd0; b_i = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_busy", {31'd0, busy4}, 32'd0);
    check_eq("rst_done", {31'd0, done4}, 32'd0);
    check_eq("rst_result", result4, 32'd0);
    check_eq("rst_result1", result1, 32'd0);
    clear = 1'b0;
    @(negedge clock); #1;

    // T1: ROL with busy/done timing on the STEP=4 instance
    drive_op(3'd4, 32'h8000_0003, 32'd2, 32'h0000_000E, 3'b111);
    check_eq("t1_busy_e0", {31'd0, busy4}, 32'd1);
    check_eq("t1_done_e0", {31'd0, done4}, 32'd0);
    @(posedge clock); #1;
    check_eq("t1_busy_e1", {31'd0, busy4}, 32'd0);
    check_eq("t1_done_e1", {31'd0, done4}, 32'd1);
    @(posedge clock); #1;
    check_eq("t1_done_e2", {31'd0, done4}, 32'd0);
    wait_all();

    // T2: sign-preserving SHRA and logical SHR by 31
    drive_op(3'd1, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 3'b111);
    wait_all();
    drive_op(3'd0, 32'h8000_0000, 32'd31, 32'h0000_0001, 3'b111);
    wait_all();

    // T3: ROR by 1, SHL by 33 (mod 32), amount 0 for every op code
    drive_op(3'd3, 32'h0000_0001, 32'd1, 32'h8000_0000, 3'b111);
    wait_all();
    drive_op(3'd2, 32'h0000_0001, 32'd33, 32'h0000_0002, 3'b111);
    wait_all();
    for (int o = 0; o < 8; o++) begin
      drive_op(3'(o), 32'hA5C3_0F96, 32'd64, 32'hA5C3_0F96, 3'b111);
      wait_all();
    end
    // reserved op with nonzero amount still returns a in one cycle
    drive_op(3'd6, 32'h1234_5678, 32'd7, 32'h1234_5678, 3'b111);
    wait_all();

    // T4: clear mid-RUN, then start during busy is ignored
    drive_op(3'd4, 32'h1234_5678, 32'd20, 32'h6781_2345, 3'b010);
    @(posedge clock); #1;
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    q4.delete();
    check_eq("t4_clr_busy", {31'd0, busy4}, 32'd0);
    check_eq("t4_clr_done", {31'd0, done4}, 32'd0);
    check_eq("t4_clr_result", result4, 32'd0);
    repeat (6) @(posedge clock);
    #1;
    check_eq("t4_idle_busy", {31'd0, busy4}, 32'd0);
    drive_op(3'd4, 32'h1234_5678, 32'd20, 32'h6781_2345, 3'b010);
    @(posedge clock); #1;
    start4 = 1'b1; op_i = 3'd0; a_i = 32'hDEAD_BEEF; b_i = 32'd1;
    @(posedge clock); #1;
    start4 = 1'b0;
    wait_all();

    // T5: back-to-back start during DONE, prior result held meanwhile
    drive_op(3'd2, 32'h0000_0003, 32'd1, 32'h0000_0006, 3'b010);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock); #1;
      if (done4) break;
    end
    check_eq("t5_done_seen", {31'd0, done4}, 32'd1);
    drive_op(3'd2, 32'h0000_000F, 32'd4, 32'h0000_00F0, 3'b010);
    check_eq("t5_busy", {31'd0, busy4}, 32'd1);
    check_eq("t5_held", result4, 32'h0000_0006);
    wait_all();

    // T6: random ops against the reference model on all three step sizes
    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      drive_op(ro, ra, rb, ref_model(ro, ra, rb), 3'b111);
      wait_all();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
